// File: rtl/game_pkg.sv
// Shared types and 7-segment glyphs for the game round engine.
// Glyphs are active-low, bit 0 = segment a ... bit 6 = segment g, bit 7 = dp.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    ANSWER = 2'd2,
    RESULT = 2'd3
  } gameState_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] LFSR_MASK = 8'hB8;

  localparam logic [7:0] SYM_SEG0 = 8'hFE;  // top bar
  localparam logic [7:0] SYM_SEG1 = 8'hCF;  // left bars
  localparam logic [7:0] SYM_SEG2 = 8'hF7;  // bottom bar
  localparam logic [7:0] SYM_SEG3 = 8'h9C;  // upper box

  localparam logic [7:0] SEG_G    = 8'hC2;
  localparam logic [7:0] SEG_O    = 8'hC0;
  localparam logic [7:0] SEG_D    = 8'hA1;
  localparam logic [7:0] SEG_B    = 8'h83;
  localparam logic [7:0] SEG_A    = 8'h88;
  localparam logic [7:0] SEG_DASH = 8'hBF;

  function automatic logic [7:0] digitSeg(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [7:0] symSeg(input logic [1:0] s);
    logic [7:0] seg;
    case (s)
      2'd0:    seg = SYM_SEG0;
      2'd1:    seg = SYM_SEG1;
      2'd2:    seg = SYM_SEG2;
      default: seg = SYM_SEG3;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/game_period_lfsr.sv
// Free-running 8-bit Galois LFSR (mask 8'hB8) that supplies target and symbols.
module sym_lfsr
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk100M,
  input  logic       Rst_n,
  output logic [7:0] lfsrVal
);

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) lfsrVal <= SEED;
    else        lfsrVal <= {1'b0, lfsrVal[7:1]} ^ (lfsrVal[0] ? LFSR_MASK : 8'h00);
  end

endmodule

// File: rtl/game_period.sv
// Round engine: flash symbols, take the player's count, judge and show the verdict.
// Optional answer timeout enabled by defining GAME_ANSWER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a gameSig rising edge, display blank
// SHOW   | one symbol per Clk1Hz tick, remaining count on seg1/seg0
// ANSWER | echo switch value, wait for submit (or timeout)
// RESULT | show GOOd / bAd for RESULT_SECS ticks, then pulse roundDone
module game_period
  import game_pkg::*;
#(
  parameter int         BASE_SYMS   = 6,
  parameter int         ANSWER_SECS = 10,
  parameter int         RESULT_SECS = 3,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       Clk100M,
  input  logic       Rst_n,
  input  logic       Clk1Hz,
  input  logic       gameSig,
  input  logic [3:0] curLevel,
  input  logic [4:0] answer,
  input  logic       submitBtn,
  output logic       roundDone,
  output logic       roundWin,
  output logic [7:0] gameSeg0,
  output logic [7:0] gameSeg1,
  output logic [7:0] gameSeg2,
  output logic [7:0] gameSeg3
);

  logic [7:0] lfsrVal;
  logic       unusedLfsrHi;

  sym_lfsr #(.SEED(LFSR_SEED)) uLfsr (
    .Clk100M (Clk100M),
    .Rst_n   (Rst_n),
    .lfsrVal (lfsrVal)
  );

  assign unusedLfsrHi = ^lfsrVal[7:4];

  // [0],[1] synchronise the slow clock, [2] holds the previous synced level
  logic [2:0] hzSync;
  logic       tickPulse;
  logic       gameSigQ;
  logic       submitQ;
  logic       gameRise;
  logic       submitRise;

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      hzSync    <= 3'b000;
      tickPulse <= 1'b0;
      gameSigQ  <= 1'b0;
      submitQ   <= 1'b0;
    end else begin
      hzSync    <= {hzSync[1:0], Clk1Hz};
      tickPulse <= hzSync[1] & ~hzSync[2];
      gameSigQ  <= gameSig;
      submitQ   <= submitBtn;
    end
  end

  assign gameRise   = gameSig & ~gameSigQ;
  assign submitRise = submitBtn & ~submitQ;

  gameState_e state;
  logic [4:0] total;
  logic [4:0] shown;
  logic [4:0] matchCnt;
  logic [1:0] target;
  logic [1:0] sym;
  logic       symValid;
  logic [7:0] secTimer;

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      roundDone <= 1'b0;
      roundWin  <= 1'b0;
      total     <= '0;
      shown     <= '0;
      matchCnt  <= '0;
      target    <= '0;
      sym       <= '0;
      symValid  <= 1'b0;
      secTimer  <= '0;
    end else begin
      roundDone <= 1'b0;
      case (state)
        IDLE: begin
          if (gameRise) begin
            total    <= 5'(BASE_SYMS) + {1'b0, curLevel};
            target   <= lfsrVal[3:2];
            shown    <= '0;
            matchCnt <= '0;
            symValid <= 1'b0;
            roundWin <= 1'b0;
            state    <= SHOW;
          end
        end
        SHOW: begin
          if (tickPulse) begin
            // the extra tick keeps the last symbol up for a full second
            if (shown == total) begin
              state    <= ANSWER;
              secTimer <= 8'(ANSWER_SECS);
            end else begin
              sym      <= lfsrVal[1:0];
              symValid <= 1'b1;
              shown    <= shown + 5'd1;
              if (lfsrVal[1:0] == target) matchCnt <= matchCnt + 5'd1;
            end
          end
        end
        ANSWER: begin
          if (submitRise) begin
            roundWin <= (answer == matchCnt);
            state    <= RESULT;
            secTimer <= 8'(RESULT_SECS);
          end
`ifdef GAME_ANSWER_TIMEOUT_EN
          else if (tickPulse) begin
            if (secTimer == 8'd1) begin
              roundWin <= 1'b0;
              state    <= RESULT;
              secTimer <= 8'(RESULT_SECS);
            end else begin
              secTimer <= secTimer - 8'd1;
            end
          end
`endif
        end
        RESULT: begin
          if (tickPulse) begin
            if (secTimer == 8'd1) begin
              state     <= IDLE;
              roundDone <= 1'b1;
            end else begin
              secTimer <= secTimer - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [4:0] dispVal;
  logic [3:0] tens;
  logic [3:0] units;
  logic [7:0] seg0Next;
  logic [7:0] seg1Next;
  logic [7:0] seg2Next;
  logic [7:0] seg3Next;
`ifdef GAME_ANSWER_TIMEOUT_EN
  logic [3:0] remSec;
  assign remSec = (secTimer > 8'd9) ? 4'd9 : secTimer[3:0];
`endif

  always_comb begin
    dispVal = (state == ANSWER) ? answer : (total - shown);
    if (dispVal >= 5'd20) begin
      tens  = 4'd2;
      units = 4'(dispVal - 5'd20);
    end else if (dispVal >= 5'd10) begin
      tens  = 4'd1;
      units = 4'(dispVal - 5'd10);
    end else begin
      tens  = 4'd0;
      units = dispVal[3:0];
    end
  end

  always_comb begin
    seg0Next = SEG_BLANK;
    seg1Next = SEG_BLANK;
    seg2Next = SEG_BLANK;
    seg3Next = SEG_BLANK;
    case (state)
      SHOW: begin
        seg3Next = symSeg(target);
        seg2Next = symValid ? symSeg(sym) : SEG_BLANK;
        seg1Next = digitSeg(tens);
        seg0Next = digitSeg(units);
      end
      ANSWER: begin
        seg3Next = symSeg(target);
`ifdef GAME_ANSWER_TIMEOUT_EN
        seg2Next = digitSeg(remSec);
`endif
        if (answer >= 5'd20) begin
          seg1Next = SEG_DASH;
          seg0Next = SEG_DASH;
        end else begin
          seg1Next = digitSeg(tens);
          seg0Next = digitSeg(units);
        end
      end
      RESULT: begin
        if (roundWin) begin
          seg3Next = SEG_G;
          seg2Next = SEG_O;
          seg1Next = SEG_O;
          seg0Next = SEG_D;
        end else begin
          seg3Next = SEG_B;
          seg2Next = SEG_A;
          seg1Next = SEG_D;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      gameSeg0 <= SEG_BLANK;
      gameSeg1 <= SEG_BLANK;
      gameSeg2 <= SEG_BLANK;
      gameSeg3 <= SEG_BLANK;
    end else begin
      gameSeg0 <= seg0Next;
      gameSeg1 <= seg1Next;
      gameSeg2 <= seg2Next;
      gameSeg3 <= seg3Next;
    end
  end

endmodule

// File: tb/tb_game_period.sv
// Bench for game_period: directed rounds, roundDone results checked through a scoreboard.
`timescale 1ns/1ps
module tb_game_period;

  logic       Clk100M;
  logic       Rst_n;
  logic       Clk1Hz;
  logic       gameSig;
  logic [3:0] curLevel;
  logic [4:0] answer;
  logic       submitBtn;
  logic       roundDone;
  logic       roundWin;
  logic [7:0] gameSeg0, gameSeg1, gameSeg2, gameSeg3;

  game_period dut (
    .Clk100M   (Clk100M),
    .Rst_n     (Rst_n),
    .Clk1Hz    (Clk1Hz),
    .gameSig   (gameSig),
    .curLevel  (curLevel),
    .answer    (answer),
    .submitBtn (submitBtn),
    .roundDone (roundDone),
    .roundWin  (roundWin),
    .gameSeg0  (gameSeg0),
    .gameSeg1  (gameSeg1),
    .gameSeg2  (gameSeg2),
    .gameSeg3  (gameSeg3)
  );

  initial Clk100M = 1'b0;
  always #5 Clk100M = ~Clk100M;

  localparam logic [7:0] BL = 8'hFF;
  localparam logic [7:0] TB_DIGIT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [7:0] TB_SYM [4] = '{8'hFE, 8'hCF, 8'hF7, 8'h9C};
  localparam logic [7:0] GL_G = 8'hC2, GL_O = 8'hC0, GL_D = 8'hA1,
                         GL_B = 8'h83, GL_A = 8'h88, GL_DASH = 8'hBF;

  // reference Galois LFSR, same reset and clock as the design's symbol source
  logic [7:0] mLfsr;
  always @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) mLfsr <= 8'hA5;
    else        mLfsr <= {1'b0, mLfsr[7:1]} ^ (mLfsr[0] ? 8'hB8 : 8'h00);
  end

  typedef struct packed {
    logic        win;
    logic [31:0] segs;
  } sbItem_t;

  sbItem_t sbQ[$];
  int nChecks = 0;
  int nBad = 0;
  int doneCount = 0;
  int tgt, tot, mcount;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] segsNow();
    return {gameSeg3, gameSeg2, gameSeg1, gameSeg0};
  endfunction

  function automatic logic [15:0] decSeg(input int v);
    return {TB_DIGIT[v / 10], TB_DIGIT[v % 10]};
  endfunction

  function automatic logic [31:0] resultSegs(input bit win);
    return win ? {GL_G, GL_O, GL_O, GL_D} : {GL_B, GL_A, GL_D, BL};
  endfunction

  // monitor: every roundDone pulse must match the oldest expected verdict
  always @(negedge Clk100M) begin
    if (Rst_n && roundDone) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        nChecks++;
        nBad++;
        $display("FAIL unexpected roundDone: got 1 expected 0 at %0t", $time);
      end else begin
        sbItem_t e;
        e = sbQ.pop_front();
        check("roundDone verdict", {7'd0, roundWin, segsNow()}, {7'd0, e.win, e.segs});
      end
    end
  end

  // tick action happens 3 cycles after the rise; v is the LFSR value it samples
  task automatic doTick(input bit subAtAct, output logic [7:0] v);
    @(negedge Clk100M);
    Clk1Hz = 1'b1;
    repeat (3) @(negedge Clk100M);
    v = mLfsr;
    Clk1Hz = 1'b0;
    if (subAtAct) submitBtn = 1'b1;
    repeat (3) @(negedge Clk100M);
  endtask

  task automatic startRound(input int lvl, input bit hold);
    @(negedge Clk100M);
    curLevel = 4'(lvl);
    gameSig  = 1'b1;
    tgt      = int'(mLfsr[3:2]);
    tot      = 6 + lvl;
    mcount   = 0;
    @(negedge Clk100M);
    if (!hold) gameSig = 1'b0;
    @(negedge Clk100M);
    check("start display", {7'd0, roundWin, segsNow()},
          {7'd0, 1'b0, TB_SYM[tgt], BL, decSeg(tot)});
  endtask

  task automatic showAll();
    logic [7:0] v;
    int s;
    for (int k = 1; k <= tot; k++) begin
      doTick(1'b0, v);
      s = int'(v[1:0]);
      if (s == tgt) mcount++;
      check("show display", {8'd0, segsNow()}, {8'd0, TB_SYM[tgt], TB_SYM[s], decSeg(tot - k)});
    end
    doTick(1'b0, v);
`ifdef GAME_ANSWER_TIMEOUT_EN
    check("answer entry", {24'd0, gameSeg3, gameSeg2}, {24'd0, TB_SYM[tgt], TB_DIGIT[9]});
`else
    check("answer entry", {24'd0, gameSeg3, gameSeg2}, {24'd0, TB_SYM[tgt], BL});
`endif
  endtask

  task automatic checkAnswerDisp(input int a);
    answer = 5'(a);
    repeat (2) @(negedge Clk100M);
    if (a >= 20) check("answer echo", {24'd0, gameSeg1, gameSeg0}, {24'd0, GL_DASH, GL_DASH});
    else         check("answer echo", {24'd0, gameSeg1, gameSeg0}, {24'd0, decSeg(a)});
  endtask

  task automatic waitDone(input bit expWin);
    logic [7:0] v;
    int dc;
    dc = doneCount;
    doTick(1'b0, v);
    doTick(1'b0, v);
    check("no early roundDone", 40'(doneCount), 40'(dc));
    doTick(1'b0, v);
    check("roundDone count", 40'(doneCount), 40'(dc + 1));
    check("idle after done", {6'd0, roundDone, roundWin, segsNow()},
          {6'd0, 1'b0, expWin, 32'hFFFF_FFFF});
  endtask

  task automatic finishRound(input int ans, input bit expWin);
    checkAnswerDisp(ans);
    @(negedge Clk100M);
    submitBtn = 1'b1;
    sbQ.push_back({expWin, resultSegs(expWin)});
    repeat (2) @(negedge Clk100M);
    submitBtn = 1'b0;
    check("result display", {7'd0, roundWin, segsNow()}, {7'd0, expWin, resultSegs(expWin)});
    waitDone(expWin);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int dc;
    Rst_n = 1'b0; Clk1Hz = 1'b0; gameSig = 1'b0; curLevel = 4'd0;
    answer = 5'd0; submitBtn = 1'b0;
    repeat (3) @(negedge Clk100M);
    check("reset state", {6'd0, roundDone, roundWin, segsNow()}, {6'd0, 1'b0, 1'b0, 32'hFFFF_FFFF});
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk100M);

    // round 1: level 2, answer echo vectors, then a correct answer
    startRound(2, 1'b0);
    showAll();
    checkAnswerDisp(7);
    checkAnswerDisp(13);
    checkAnswerDisp(19);
    checkAnswerDisp(20);
    checkAnswerDisp(31);
`ifndef GAME_ANSWER_TIMEOUT_EN
    dc = doneCount;
    repeat (12) doTick(1'b0, v);
    check("answer waits", {7'd0, 40'(doneCount) == 40'(dc), gameSeg2, gameSeg1, gameSeg0, 8'd0},
          {7'd0, 1'b1, BL, GL_DASH, GL_DASH, 8'd0});
`endif
    finishRound(mcount, 1'b1);

    // round 2: off-by-one answer loses
    startRound(2, 1'b0);
    showAll();
    finishRound(mcount + 1, 1'b0);

    // round 3: maximum level, 21 symbols
    startRound(15, 1'b0);
    showAll();
    finishRound(mcount, 1'b1);

    // round 4: gameSig held high with extra edges during SHOW
    startRound(0, 1'b1);
    @(negedge Clk100M) gameSig = 1'b0;
    @(negedge Clk100M) gameSig = 1'b1;
    showAll();
    finishRound(mcount, 1'b1);
    dc = doneCount;
    repeat (3) doTick(1'b0, v);
    check("held gameSig stays idle", {7'd0, 40'(doneCount) == 40'(dc), segsNow()},
          {7'd0, 1'b1, 32'hFFFF_FFFF});
    gameSig = 1'b0;

    // round 5: reset mid-SHOW aborts without roundDone
    startRound(1, 1'b0);
    doTick(1'b0, v);
    doTick(1'b0, v);
    @(negedge Clk100M) Rst_n = 1'b0;
    @(negedge Clk100M);
    check("reset mid show", {6'd0, roundDone, roundWin, segsNow()}, {6'd0, 1'b0, 1'b0, 32'hFFFF_FFFF});
    Rst_n = 1'b1;
    dc = doneCount;
    repeat (2) doTick(1'b0, v);
    check("idle after reset", {7'd0, 40'(doneCount) == 40'(dc), segsNow()},
          {7'd0, 1'b1, 32'hFFFF_FFFF});

`ifdef GAME_ANSWER_TIMEOUT_EN
    // timeout with a correct answer on the switches still loses
    startRound(1, 1'b0);
    showAll();
    answer = 5'(mcount);
    for (int i = 1; i <= 9; i++) begin
      doTick(1'b0, v);
      check("timeout seconds", {32'd0, gameSeg2}, {32'd0, TB_DIGIT[(10 - i) > 9 ? 9 : 10 - i]});
    end
    sbQ.push_back({1'b0, resultSegs(1'b0)});
    doTick(1'b0, v);
    check("timeout result", {7'd0, roundWin, segsNow()}, {7'd0, 1'b0, resultSegs(1'b0)});
    waitDone(1'b0);

    // submit on the same cycle as the final timeout tick wins
    startRound(0, 1'b0);
    showAll();
    answer = 5'(mcount);
    repeat (9) doTick(1'b0, v);
    sbQ.push_back({1'b1, resultSegs(1'b1)});
    doTick(1'b1, v);
    submitBtn = 1'b0;
    check("submit beats timeout", {7'd0, roundWin, segsNow()}, {7'd0, 1'b1, resultSegs(1'b1)});
    waitDone(1'b1);
`endif

    check("scoreboard drained", 40'(sbQ.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
